// File: rtl/otbn_pq_pkg.sv
// Shared PQ definitions: control-SPR addresses, request opcodes and the
// decoder's shared update strobes.
package otbn_pq_pkg;

    typedef enum logic [7:0] {
        PqCtrlSprM    = 8'h00,
        PqCtrlSprJ2   = 8'h01,
        PqCtrlSprJ    = 8'h02,
        PqCtrlSprIdx0 = 8'h03,
        PqCtrlSprIdx1 = 8'h04,
        PqCtrlSprMode = 8'h05,
        PqCtrlSprX    = 8'h06,
        PqCtrlSprY    = 8'h07
    } pqctrlspr_e;

    // Encoding 2'd3 is reserved and reported as an error.
    typedef enum logic [1:0] {
        PqctrlReqRead  = 2'd0,
        PqctrlReqWrite = 2'd1,
        PqctrlReqRs    = 2'd2
    } pqctrl_req_op_e;

    typedef struct packed {
        logic sl_m;
        logic sl_j2;
        logic inc_j;
        logic inc_idx;
        logic set_idx;
        logic inc_x;
        logic inc_y;
    } insn_dec_shared_pq_t;

endpackage

// File: rtl/otbn_pq_mod5_ctr.sv
// 3-bit Keccak lane coordinate counter: load, or increment modulo 5.
module otbn_pq_mod5_ctr
    import otbn_pq_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ld_i,
    input  logic [2:0] ld_val_i,
    input  logic       inc_i,
    output logic [2:0] cnt_o
);

    logic [2:0] cnt_q, cnt_d;

    // Loads win over increments; any loaded value >= 4 wraps to 0 on the next increment.
    always_comb begin
        cnt_d = cnt_q;
        if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (inc_i) begin
            cnt_d = (cnt_q >= 3'd4) ? 3'd0 : cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/otbn_pq_ctrlspr.sv
// PQ control-SPR responder: loop-control registers with read/write/read-set
// access and decoder strobe updates.
module otbn_pq_ctrlspr
    import otbn_pq_pkg::*;
#(
    parameter int unsigned PqLen = 32,
    parameter int unsigned IdxW  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    input  logic [1:0]       req_op_i,
    input  logic [7:0]       req_addr_i,
    input  logic [PqLen-1:0] req_wdata_i,
    output logic             rsp_valid_o,
    output logic [PqLen-1:0] rsp_rdata_o,
    output logic             rsp_err_o,
    input  logic             sl_m_i,
    input  logic             sl_j2_i,
    input  logic             inc_j_i,
    input  logic             inc_idx_i,
    input  logic             set_idx_i,
    input  logic             inc_x_i,
    input  logic             inc_y_i,
    output logic [PqLen-1:0] m_o,
    output logic [PqLen-1:0] j2_o,
    output logic [PqLen-1:0] j_o,
    output logic [PqLen-1:0] mode_o,
    output logic [IdxW-1:0]  idx0_o,
    output logic [IdxW-1:0]  idx1_o,
    output logic [2:0]       x_o,
    output logic [2:0]       y_o,
    output logic             j_wrap_o
);

    insn_dec_shared_pq_t stb;
    assign stb = '{sl_m: sl_m_i, sl_j2: sl_j2_i, inc_j: inc_j_i, inc_idx: inc_idx_i,
                   set_idx: set_idx_i, inc_x: inc_x_i, inc_y: inc_y_i};

    logic [PqLen-1:0] m_q, m_d, j2_q, j2_d, j_q, j_d, mode_q, mode_d;
    logic [IdxW-1:0]  idx0_q, idx0_d, idx1_q, idx1_d;
    logic [2:0]       x_cnt, y_cnt;
    logic             j_wrap_q, j_wrap_d;
    logic             rsp_valid_q, rsp_err_q;
    logic [PqLen-1:0] rsp_rdata_q, rsp_rdata_d;

    pqctrlspr_e       addr;
    pqctrl_req_op_e   op;
    logic             req_err, req_acc, req_commit;
    logic [PqLen-1:0] rd_val, wr_val;

    assign addr       = pqctrlspr_e'(req_addr_i);
    assign op         = pqctrl_req_op_e'(req_op_i);
    assign req_err    = req_valid_i && ((req_addr_i > 8'h07) || (req_op_i == 2'd3));
    assign req_acc    = req_valid_i && !req_err;
    assign req_commit = req_acc && (op != PqctrlReqRead);

    always_comb begin
        rd_val = '0;
        unique case (addr)
            PqCtrlSprM:    rd_val = m_q;
            PqCtrlSprJ2:   rd_val = j2_q;
            PqCtrlSprJ:    rd_val = j_q;
            PqCtrlSprIdx0: rd_val = PqLen'(idx0_q);
            PqCtrlSprIdx1: rd_val = PqLen'(idx1_q);
            PqCtrlSprMode: rd_val = mode_q;
            PqCtrlSprX:    rd_val = PqLen'(x_cnt);
            PqCtrlSprY:    rd_val = PqLen'(y_cnt);
            default:       rd_val = '0;
        endcase
    end

    // One commit value serves write and read-set; narrow registers keep the low bits.
    assign wr_val      = (op == PqctrlReqWrite) ? req_wdata_i : (rd_val | req_wdata_i);
    assign rsp_rdata_d = (req_acc && op != PqctrlReqWrite) ? rd_val : '0;

    always_comb begin
        m_d      = stb.sl_m  ? (m_q << 1)  : m_q;
        j2_d     = stb.sl_j2 ? (j2_q << 1) : j2_q;
        j_d      = j_q;
        j_wrap_d = 1'b0;
        idx0_d   = idx0_q;
        idx1_d   = idx1_q;
        mode_d   = mode_q;
        if (stb.inc_j) begin
            if (j_q + PqLen'(1) == j2_q) begin
                j_d      = '0;
                j_wrap_d = 1'b1;
            end else begin
                j_d = j_q + PqLen'(1);
            end
        end
        if (stb.set_idx) begin
            idx0_d = idx1_q;
            idx1_d = idx1_q + m_q[IdxW-1:0];
        end else if (stb.inc_idx) begin
            idx0_d = idx0_q + IdxW'(1);
            idx1_d = idx1_q + IdxW'(1);
        end
        if (req_commit) begin
            unique case (addr)
                PqCtrlSprM:    m_d    = wr_val;
                PqCtrlSprJ2:   j2_d   = wr_val;
                PqCtrlSprJ: begin
                    j_d      = wr_val;
                    j_wrap_d = 1'b0;
                end
                PqCtrlSprIdx0: idx0_d = wr_val[IdxW-1:0];
                PqCtrlSprIdx1: idx1_d = wr_val[IdxW-1:0];
                PqCtrlSprMode: mode_d = wr_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_q         <= PqLen'(1);
            j2_q        <= PqLen'(1);
            j_q         <= '0;
            mode_q      <= '0;
            idx0_q      <= '0;
            idx1_q      <= '0;
            j_wrap_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            m_q         <= m_d;
            j2_q        <= j2_d;
            j_q         <= j_d;
            mode_q      <= mode_d;
            idx0_q      <= idx0_d;
            idx1_q      <= idx1_d;
            j_wrap_q    <= j_wrap_d;
            rsp_valid_q <= req_valid_i;
            rsp_err_q   <= req_err;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    otbn_pq_mod5_ctr u_x_ctr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ld_i     (req_commit && addr == PqCtrlSprX),
        .ld_val_i (wr_val[2:0]),
        .inc_i    (stb.inc_x),
        .cnt_o    (x_cnt)
    );

    otbn_pq_mod5_ctr u_y_ctr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ld_i     (req_commit && addr == PqCtrlSprY),
        .ld_val_i (wr_val[2:0]),
        .inc_i    (stb.inc_y),
        .cnt_o    (y_cnt)
    );

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign m_o         = m_q;
    assign j2_o        = j2_q;
    assign j_o         = j_q;
    assign mode_o      = mode_q;
    assign idx0_o      = idx0_q;
    assign idx1_o      = idx1_q;
    assign x_o         = x_cnt;
    assign y_o         = y_cnt;
    assign j_wrap_o    = j_wrap_q;

endmodule
